// File: rtl/biquad_seq_pkg.sv
// Shared types and constants for the biquad coefficient sequencer.
package biquad_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_WRITE = 3'd2,
    ST_UPD   = 3'd3,
    ST_DONE  = 3'd4
  } seq_state_e;

  localparam logic [6:0] UPDATE_OFS    = 7'h00;
  localparam logic [6:0] FIR_OFS       = 7'h04;
  localparam logic [6:0] POLE_OFS_BASE = 7'h10;

  localparam int OFS_W   = 7;
  localparam int DATA_W  = 18;
  localparam int ENTRY_W = OFS_W + DATA_W;

  localparam logic [DATA_W-1:0] UPDATE_DATA = 18'h00001;

endpackage

// File: rtl/biquad_seq_list_ram.sv
// Command list storage: simple dual-port RAM, one write port, registered read port.
module biquad_seq_list_ram
  import biquad_seq_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic               clk_i,
  input  logic               we_i,
  input  logic [AW-1:0]      wadr_i,
  input  logic [ENTRY_W-1:0] wdat_i,
  input  logic [AW-1:0]      radr_i,
  output logic [ENTRY_W-1:0] rdat_o
);

  logic [ENTRY_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[wadr_i] <= wdat_i;
    end
    rdat_o <= mem_q[radr_i];
  end

endmodule

// File: rtl/biquad_coeff_sequencer.sv
// WISHBONE master replaying a host-written coefficient list into one biquad8 wrapper window.
// Define BIQUAD_SEQ_BROADCAST_EN to enable replaying the list to every filter with a global update.
module biquad_coeff_sequencer
  import biquad_seq_pkg::*;
#(
  parameter int NFILT     = 16,
  parameter int LISTDEPTH = 16,
  parameter int TIMEOUT   = 255
) (
  input  logic                                 wb_clk_i,
  input  logic                                 wb_rst_ni,
  input  logic                                 lst_wr_i,
  input  logic [$clog2(LISTDEPTH)-1:0]         lst_adr_i,
  input  logic [ENTRY_W-1:0]                   lst_dat_i,
  input  logic                                 start_i,
  input  logic [$clog2(LISTDEPTH):0]           count_i,
  input  logic [$clog2(NFILT)-1:0]             filt_i,
  input  logic                                 bcast_i,
  output logic                                 busy_o,
  output logic                                 done_o,
  output logic                                 err_o,
  output logic                                 m_cyc_o,
  output logic                                 m_stb_o,
  output logic                                 m_we_o,
  output logic [OFS_W+$clog2(NFILT)-1:0]       m_adr_o,
  output logic [31:0]                          m_dat_o,
  output logic [3:0]                           m_sel_o,
  input  logic                                 m_ack_i,
  input  logic                                 m_err_i,
  output logic                                 global_update_o
);

  localparam int FW = $clog2(NFILT);
  localparam int LW = $clog2(LISTDEPTH);
  localparam int CW = LW + 1;
  localparam logic [CW-1:0] MAX_COUNT = CW'(LISTDEPTH);
  localparam logic [FW-1:0] LAST_FILT = FW'(NFILT - 1);
  localparam logic [7:0]    TMO_LAST  = 8'(TIMEOUT - 1);

  seq_state_e         state_q, state_d;
  logic [CW-1:0]      idx_q, idx_d, cnt_q, cnt_d;
  logic [FW-1:0]      filt_q, filt_d;
  logic               bcast_q, bcast_d;
  logic               err_q, err_d;
  logic               cyc_q, cyc_d;
  logic [OFS_W-1:0]   ofs_q, ofs_d;
  logic [DATA_W-1:0]  dat_q, dat_d;
  logic [7:0]         tmo_q, tmo_d;
  logic [ENTRY_W-1:0] ramRdat;
  logic [CW-1:0]      idxNext;
  logic               startAccept, busAbort, busDone, bcastReq, listWe;

  assign startAccept = (state_q == ST_IDLE) && start_i;
  assign busy_o      = (state_q == ST_FETCH) || (state_q == ST_WRITE) || (state_q == ST_UPD);
  assign listWe      = lst_wr_i && !busy_o && !startAccept;

`ifdef BIQUAD_SEQ_BROADCAST_EN
  assign bcastReq        = bcast_i;
  assign global_update_o = (state_q == ST_UPD) && bcast_q;
`else
  logic unusedBcast;
  assign unusedBcast     = bcast_i;
  assign bcastReq        = 1'b0;
  assign global_update_o = 1'b0;
`endif

  biquad_seq_list_ram #(
    .DEPTH (LISTDEPTH),
    .AW    (LW)
  ) u_list (
    .clk_i  (wb_clk_i),
    .we_i   (listWe),
    .wadr_i (lst_adr_i),
    .wdat_i (lst_dat_i),
    .radr_i (idx_q[LW-1:0]),
    .rdat_o (ramRdat)
  );

  // An error response wins over a simultaneous ack.
  assign busAbort = cyc_q && (m_err_i || (!m_ack_i && (tmo_q == TMO_LAST)));
  assign busDone  = cyc_q && m_ack_i && !m_err_i;
  assign idxNext  = idx_q + CW'(1);

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      filt_q  <= '0;
      bcast_q <= 1'b0;
      err_q   <= 1'b0;
      cyc_q   <= 1'b0;
      ofs_q   <= '0;
      dat_q   <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      filt_q  <= filt_d;
      bcast_q <= bcast_d;
      err_q   <= err_d;
      cyc_q   <= cyc_d;
      ofs_q   <= ofs_d;
      dat_q   <= dat_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    filt_d  = filt_q;
    bcast_d = bcast_q;
    err_d   = err_q;
    cyc_d   = cyc_q;
    ofs_d   = ofs_q;
    dat_d   = dat_q;
    tmo_d   = tmo_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          cnt_d   = (count_i > MAX_COUNT) ? MAX_COUNT : count_i;
          filt_d  = bcastReq ? '0 : filt_i;
          bcast_d = bcastReq;
          err_d   = 1'b0;
          idx_d   = '0;
          state_d = (count_i != '0) ? ST_FETCH : ST_UPD;
        end
      end
      ST_FETCH: state_d = ST_WRITE;
      ST_WRITE: begin
        // First WRITE cycle captures the RAM word; strobes rise on the next one.
        if (!cyc_q) begin
          cyc_d = 1'b1;
          tmo_d = '0;
          ofs_d = ramRdat[ENTRY_W-1 -: OFS_W];
          dat_d = ramRdat[DATA_W-1:0];
        end else if (busAbort) begin
          cyc_d   = 1'b0;
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else if (busDone) begin
          cyc_d = 1'b0;
          idx_d = idxNext;
          if (idxNext < cnt_q) begin
            state_d = ST_FETCH;
          end else if (bcast_q && (filt_q != LAST_FILT)) begin
            filt_d  = filt_q + FW'(1);
            idx_d   = '0;
            state_d = ST_FETCH;
          end else begin
            state_d = ST_UPD;
          end
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      ST_UPD: begin
        if (bcast_q) begin
          state_d = ST_DONE;
        end else if (!cyc_q) begin
          cyc_d = 1'b1;
          tmo_d = '0;
          ofs_d = UPDATE_OFS;
          dat_d = UPDATE_DATA;
        end else if (busAbort) begin
          cyc_d   = 1'b0;
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else if (busDone) begin
          cyc_d   = 1'b0;
          state_d = ST_DONE;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign done_o  = (state_q == ST_DONE);
  assign err_o   = err_q;
  assign m_cyc_o = cyc_q;
  assign m_stb_o = cyc_q;
  assign m_we_o  = cyc_q;
  assign m_adr_o = {filt_q, ofs_q & 7'h7C};
  assign m_dat_o = {{(32-DATA_W){1'b0}}, dat_q};
  assign m_sel_o = 4'hF;

endmodule

// File: tb/tb_biquad_coeff_sequencer.sv
// Scoreboard bench for biquad_coeff_sequencer: stimulus pushes expected bus writes, a monitor pops on each ack.
`timescale 1ns/1ps
module tb_biquad_coeff_sequencer;
  import biquad_seq_pkg::*;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_ni = 1'b0;
  logic        lst_wr_i = 1'b0;
  logic [3:0]  lst_adr_i = '0;
  logic [24:0] lst_dat_i = '0;
  logic        start_i = 1'b0;
  logic [4:0]  count_i = '0;
  logic [3:0]  filt_i = '0;
  logic        bcast_i = 1'b0;
  logic        busy_o, done_o, err_o, m_cyc_o, m_stb_o, m_we_o, global_update_o;
  logic [10:0] m_adr_o;
  logic [31:0] m_dat_o;
  logic [3:0]  m_sel_o;
  logic        m_ack_i, m_err_i, errNow;

  typedef struct {
    logic [31:0] adr;
    logic [31:0] dat;
  } busTxn_t;

  busTxn_t expQ[$];
  int checks = 0;
  int failures = 0;
  int slvMode = 0;
  int txnCount = 0;
  int errAt = -1;
  int stbRun = 0;
  int stbRunMax = 0;
  int globalCount = 0;

  biquad_coeff_sequencer dut (
    .wb_clk_i        (wb_clk_i),
    .wb_rst_ni       (wb_rst_ni),
    .lst_wr_i        (lst_wr_i),
    .lst_adr_i       (lst_adr_i),
    .lst_dat_i       (lst_dat_i),
    .start_i         (start_i),
    .count_i         (count_i),
    .filt_i          (filt_i),
    .bcast_i         (bcast_i),
    .busy_o          (busy_o),
    .done_o          (done_o),
    .err_o           (err_o),
    .m_cyc_o         (m_cyc_o),
    .m_stb_o         (m_stb_o),
    .m_we_o          (m_we_o),
    .m_adr_o         (m_adr_o),
    .m_dat_o         (m_dat_o),
    .m_sel_o         (m_sel_o),
    .m_ack_i         (m_ack_i),
    .m_err_i         (m_err_i),
    .global_update_o (global_update_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  // Slave model: mode 0 zero-wait ack, mode 1 never responds, mode 2 errors on transaction errAt.
  assign errNow  = (slvMode == 2) && (txnCount == errAt);
  assign m_ack_i = (slvMode != 1) && m_cyc_o && m_stb_o && !errNow;
  assign m_err_i = m_cyc_o && m_stb_o && errNow;

  always @(posedge wb_clk_i) begin
    if (m_cyc_o && m_stb_o && (m_ack_i || m_err_i)) txnCount <= txnCount + 1;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  always @(negedge wb_clk_i) begin
    busTxn_t t;
    if (m_cyc_o && m_stb_o) begin
      stbRun++;
      if (stbRun > stbRunMax) stbRunMax = stbRun;
    end else begin
      stbRun = 0;
    end
    if (m_cyc_o && m_stb_o && m_ack_i && !m_err_i) begin
      if (expQ.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_write actual adr=0x%0h dat=0x%0h expected no write", m_adr_o, m_dat_o);
      end else begin
        t = expQ.pop_front();
        checkOutput("bus_adr", 32'(m_adr_o), t.adr);
        checkOutput("bus_dat", m_dat_o, t.dat);
        checkOutput("bus_we_sel", {27'd0, m_we_o, m_sel_o}, 32'h1F);
      end
    end
    if (global_update_o) globalCount++;
  end

  task automatic pushExp(input logic [31:0] adr, input logic [31:0] dat);
    busTxn_t t;
    t.adr = adr;
    t.dat = dat;
    expQ.push_back(t);
  endtask

  task automatic writeEntry(input logic [3:0] a, input logic [6:0] ofs, input logic [17:0] d);
    lst_wr_i  = 1'b1;
    lst_adr_i = a;
    lst_dat_i = {ofs, d};
    @(posedge wb_clk_i); #1;
    lst_wr_i  = 1'b0;
  endtask

  task automatic applyStimulus(input logic [4:0] count, input logic [3:0] filt, input logic bcast);
    start_i = 1'b1;
    count_i = count;
    filt_i  = filt;
    bcast_i = bcast;
    @(posedge wb_clk_i); #1;
    start_i  = 1'b0;
    bcast_i  = 1'b0;
    lst_wr_i = 1'b0;
  endtask

  // Latency counts the start cycle as cycle 1 through the cycle where done_o is high.
  task automatic waitDone(input int budget, output int lat, output bit ok);
    lat = 1;
    ok  = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge wb_clk_i);
      lat++;
      if (done_o) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic runSeq(input string name, input logic [4:0] count, input logic [3:0] filt,
                        input logic bcast, input int expLat, input logic expErr);
    int lat;
    bit ok;
    applyStimulus(count, filt, bcast);
    waitDone(600, lat, ok);
    checkOutput({name, "_done_seen"}, 32'(ok), 32'd1);
    if (ok) begin
      if (expLat > 0) checkOutput({name, "_latency"}, 32'(lat), 32'(expLat));
      checkOutput({name, "_err"}, 32'(err_o), 32'(expErr));
      checkOutput({name, "_busy_at_done"}, 32'(busy_o), 32'd0);
      checkOutput({name, "_gupd_at_done"}, 32'(global_update_o), 32'd0);
      checkOutput({name, "_pending_writes"}, 32'(expQ.size()), 32'd0);
    end
    expQ.delete();
    @(negedge wb_clk_i);
    checkOutput({name, "_done_one_cycle"}, 32'(done_o), 32'd0);
    @(posedge wb_clk_i); #1;
  endtask

  initial begin
    int txnBase;
    int lat;
    bit ok;
    #22;
    checkOutput("reset_busy", 32'(busy_o), 32'd0);
    checkOutput("reset_done", 32'(done_o), 32'd0);
    checkOutput("reset_err", 32'(err_o), 32'd0);
    checkOutput("reset_cyc", {30'd0, m_cyc_o, m_stb_o}, 32'd0);
    checkOutput("reset_adr", 32'(m_adr_o), 32'd0);
    checkOutput("reset_gupd", 32'(global_update_o), 32'd0);
    @(negedge wb_clk_i);
    wb_rst_ni = 1'b1;
    @(posedge wb_clk_i); #1;

    writeEntry(4'd0, FIR_OFS, 18'h00123);
    writeEntry(4'd1, POLE_OFS_BASE, 18'h3FFFF);
    pushExp(32'h184, 32'h00123);
    pushExp(32'h190, 32'h3FFFF);
    pushExp(32'h180, 32'h1);
    runSeq("basic", 5'd2, 4'd3, 1'b0, 10, 1'b0);

    pushExp(32'h780, 32'h1);
    runSeq("count0", 5'd0, 4'd15, 1'b0, 4, 1'b0);

    slvMode   = 1;
    stbRunMax = 0;
    runSeq("timeout", 5'd1, 4'd2, 1'b0, 259, 1'b1);
    checkOutput("timeout_stb_cycles", 32'(stbRunMax), 32'd255);
    checkOutput("timeout_err_sticky", 32'(err_o), 32'd1);
    slvMode = 0;
    pushExp(32'h000, 32'h1);
    runSeq("err_clear", 5'd0, 4'd0, 1'b0, 4, 1'b0);

    writeEntry(4'd0, 7'h10, 18'h00011);
    writeEntry(4'd1, 7'h14, 18'h00022);
    writeEntry(4'd2, 7'h18, 18'h00033);
    writeEntry(4'd3, 7'h1C, 18'h00044);
    pushExp(32'h290, 32'h11);
    txnBase = txnCount;
    errAt   = txnBase + 1;
    slvMode = 2;
    runSeq("midErr", 5'd4, 4'd5, 1'b0, -1, 1'b1);
    checkOutput("midErr_txns", 32'(txnCount - txnBase), 32'd2);
    slvMode = 0;

    pushExp(32'h210, 32'h11);
    pushExp(32'h214, 32'h22);
    pushExp(32'h200, 32'h1);
    txnBase = txnCount;
    applyStimulus(5'd2, 4'd4, 1'b0);
    @(posedge wb_clk_i); #1;
    start_i   = 1'b1;
    count_i   = 5'd1;
    filt_i    = 4'd7;
    lst_wr_i  = 1'b1;
    lst_adr_i = 4'd0;
    lst_dat_i = {7'h7C, 18'h2AAAA};
    @(posedge wb_clk_i); #1;
    start_i  = 1'b0;
    lst_wr_i = 1'b0;
    waitDone(100, lat, ok);
    checkOutput("busyIgnore_done_seen", 32'(ok), 32'd1);
    checkOutput("busyIgnore_pending", 32'(expQ.size()), 32'd0);
    expQ.delete();
    repeat (4) @(posedge wb_clk_i);
    #1;
    checkOutput("busyIgnore_no_restart", 32'(busy_o), 32'd0);
    checkOutput("busyIgnore_txns", 32'(txnCount - txnBase), 32'd3);

    pushExp(32'h210, 32'h11);
    pushExp(32'h214, 32'h22);
    pushExp(32'h200, 32'h1);
    lst_wr_i  = 1'b1;
    lst_adr_i = 4'd1;
    lst_dat_i = {7'h7C, 18'h15555};
    runSeq("rerun", 5'd2, 4'd4, 1'b0, 10, 1'b0);

    for (int i = 0; i < 16; i++) begin
      writeEntry(4'(i), 7'((i * 4) | (i & 3)), 18'(32'h100 + i));
      pushExp(32'(32'h300 + i * 4), 32'(32'h100 + i));
    end
    pushExp(32'h300, 32'h1);
    runSeq("clamp", 5'd31, 4'd6, 1'b0, 52, 1'b0);

    writeEntry(4'd0, FIR_OFS, 18'h00ABC);
    globalCount = 0;
`ifdef BIQUAD_SEQ_BROADCAST_EN
    for (int f = 0; f < 16; f++) pushExp(32'(f * 128 + 4), 32'hABC);
    runSeq("bcast", 5'd1, 4'd9, 1'b1, 51, 1'b0);
    checkOutput("bcast_gupd_pulses", 32'(globalCount), 32'd1);
`else
    pushExp(32'h484, 32'hABC);
    pushExp(32'h480, 32'h1);
    runSeq("bcastOff", 5'd1, 4'd9, 1'b1, 7, 1'b0);
    checkOutput("bcastOff_gupd_pulses", 32'(globalCount), 32'd0);
`endif

    slvMode = 1;
    applyStimulus(5'd0, 4'd1, 1'b0);
    repeat (3) @(negedge wb_clk_i);
    checkOutput("asyncRst_cyc_before", 32'(m_cyc_o), 32'd1);
    #2 wb_rst_ni = 1'b0;
    #1;
    checkOutput("asyncRst_strobes", {30'd0, m_cyc_o, m_stb_o}, 32'd0);
    checkOutput("asyncRst_busy", 32'(busy_o), 32'd0);
    @(negedge wb_clk_i);
    wb_rst_ni = 1'b1;
    slvMode   = 0;
    @(posedge wb_clk_i); #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout expected=bench completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
